// File: rtl/shacc_pkg.sv
// shacc_pkg: shared types for the sequential shift-accumulator (shacc_seq).
package shacc_pkg;

   // Runtime shift mode, encoded as on the in_mode port
   typedef enum logic [1:0] {
      SHACC_LSL = 2'b00,
      SHACC_LSR = 2'b01,
      SHACC_ASL = 2'b10,
      SHACC_ASR = 2'b11
   } shacc_mode_e;

   // Top-level sequencing
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } shacc_state_e;

   // Width of a counter that spans n slices, never narrower than one bit
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shacc_step.sv
// shacc_step: one combinational shift of the accumulator by one slice amount.
// Flags over-shift (amt >= WIDTH); over-shift saturates to 0 or to sign fill.
module shacc_step
   import shacc_pkg::*;
#(
   parameter int WIDTH = 10
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] amt,
   input  shacc_mode_e      mode,
   output logic [WIDTH-1:0] nxt,
   output logic             ovs
);

   // Shift by amt according to mode, with explicit over-shift saturation
   always_comb begin
      nxt = acc;
      ovs = (amt >= WIDTH'(WIDTH));
      case (mode)
         SHACC_LSL, SHACC_ASL: nxt = ovs ? '0 : (acc << amt);
         SHACC_LSR:            nxt = ovs ? '0 : (acc >> amt);
         SHACC_ASR:            nxt = ovs ? {WIDTH{acc[WIDTH-1]}}
                                         : WIDTH'($signed(acc) >>> amt);
         default:              nxt = acc;
      endcase
   end

endmodule

// File: rtl/shacc_seq.sv
// shacc_seq: sequential shift-accumulator. Accepts init/mode/amounts, then
// applies one slice per cycle (acc <op>= slice[k]) for NUM_SLICES cycles and
// presents the result under a valid/ready handshake.
// Optional: define SHACC_OVERSHIFT_FLAG_EN to add out_overshift, set when any
// applied slice had amt >= WIDTH.
module shacc_seq
   import shacc_pkg::*;
#(
   parameter int WIDTH      = 10,
   parameter int NUM_SLICES = 48
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [1:0]                  in_mode,
   input  logic [WIDTH-1:0]            in_init,
   input  logic [NUM_SLICES*WIDTH-1:0] in_amts,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            out_data
`ifdef SHACC_OVERSHIFT_FLAG_EN
   ,
   output logic                        out_overshift
`endif
);

   localparam int               IDX_W = idx_width(NUM_SLICES);
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_SLICES - 1);

   shacc_state_e                        state;
   shacc_mode_e                         mode_q;
   logic [NUM_SLICES-1:0][WIDTH-1:0]    amts_q;
   logic [IDX_W-1:0]                    idx;
   logic [WIDTH-1:0]                    acc;
   logic [WIDTH-1:0]                    acc_nxt;
   logic                                ovs;
`ifdef SHACC_OVERSHIFT_FLAG_EN
   logic                                ovf_q;
`endif

   shacc_step #(.WIDTH(WIDTH)) u_step (
      .acc  (acc),
      .amt  (amts_q[idx]),
      .mode (mode_q),
      .nxt  (acc_nxt),
      .ovs  (ovs)
   );

   assign out_data = acc;
`ifdef SHACC_OVERSHIFT_FLAG_EN
   assign out_overshift = ovf_q;
`endif

   // Control FSM and datapath; handshake outputs are registered with the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         mode_q    <= SHACC_LSL;
         amts_q    <= '0;
         idx       <= '0;
         acc       <= '0;
`ifdef SHACC_OVERSHIFT_FLAG_EN
         ovf_q     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mode_q   <= shacc_mode_e'(in_mode);
                  amts_q   <= in_amts;
                  acc      <= in_init;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
`ifdef SHACC_OVERSHIFT_FLAG_EN
                  ovf_q    <= 1'b0;
`endif
               end
            end
            RUN: begin
               acc <= acc_nxt;
`ifdef SHACC_OVERSHIFT_FLAG_EN
               ovf_q <= ovf_q | ovs;
`endif
               if (idx == LAST) begin
                  idx       <= '0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/shacc_seq.md
Name: shacc_seq

Overview:
- Sequential, parametrised shift-accumulator. Loads an initial accumulator, then applies one compound shift per cycle (acc <op>= slice[k]) across NUM_SLICES shift-amount slices of a packed operand vector.
- Successor to the single-cycle combinational shift-reduce blocks: runtime-selectable shift mode, valid/ready handshakes, bounded one-slice-per-cycle datapath.
- Sits between a packed-operand producer and a result consumer in triplicated designs.

Parameters:
- WIDTH, 10, accumulator width and width of each shift-amount slice.
- NUM_SLICES, 48, number of shift-amount slices per operation (>=1).
- IDX_W, $clog2(NUM_SLICES) (min 1), slice index counter width (derived localparam).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_mode  input  2  shift mode: 00 LSL, 01 LSR, 10 ASL, 11 ASR.
- in_init  input  WIDTH  initial accumulator value.
- in_amts  input  NUM_SLICES*WIDTH  shift amounts; slice k = in_amts[k*WIDTH +: WIDTH].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  final accumulator.

Behaviour:
- Reset: state IDLE; in_ready=1, out_valid=0, out_data=0; accumulator, index and latched mode/amounts cleared. Reset applies asynchronously and aborts any operation in progress with no partial result.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch in_mode and in_amts;
  - load acc<=in_init, idx<=0;
  - go to RUN.
- RUN: in_ready=0. Each edge applies latched slice idx: acc <= step(acc, amt[idx], mode), idx++. The edge that applies slice NUM_SLICES-1 moves to DONE.
- DONE: out_valid=1, out_data=acc, held stable while out_ready=0. On out_ready, go to IDLE; out_valid drops next cycle.
- No overlap: in_ready and out_valid are never high together.
- Latency: out_valid rises exactly NUM_SLICES cycles after the accept edge. Throughput is one request per NUM_SLICES+2 cycles minimum.
- Input changes during RUN/DONE are ignored, because the operands are latched.
- Shift semantics: shift amount is an unsigned WIDTH-bit value.
  - LSL/ASL: acc << amt, zero fill.
  - LSR: zero fill from MSB.
  - ASR: acc treated as signed, fill with acc[WIDTH-1].
- Over-shift (amt >= WIDTH): LSL/ASL/LSR give 0; ASR gives all bits = acc[WIDTH-1].
- Amount 0 leaves acc unchanged.
- NUM_SLICES=1: RUN lasts one cycle.

Optional Feature:
- Macro: SHACC_OVERSHIFT_FLAG_EN.
- Defined:
  - Adds output port out_overshift (1 bit), valid with out_data.
  - Set if any slice applied in the operation had amt >= WIDTH.
  - Cleared on accept; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package shacc_pkg:
  - typedef enum logic [1:0] shacc_mode_e {SHACC_LSL, SHACC_LSR, SHACC_ASL, SHACC_ASR};
  - typedef enum shacc_state_e {IDLE, RUN, DONE}.
- Sub-module shacc_step: purely combinational single shift.
  - Inputs: acc, amt, mode. Outputs: next acc and an overshift bit.
  - Instantiated once in shacc_seq. Reusable by a future multi-slice-per-cycle variant.

Test Plan:
- Reset mid-RUN: accept, deassert rst_n after 5 RUN cycles -> immediately in_ready=1, out_valid=0, out_data=0; next request completes normally.
- LSR basic (WIDTH=10, NUM_SLICES=48): init 10'h200, slice0=1, slice1=2, rest 0, mode LSR -> out_data 10'h040, out_valid exactly 48 cycles after accept.
- ASR sign fill: init 10'h200, slice0=3, rest 0, mode ASR -> 10'h3C0. Same stimulus with mode LSR -> 10'h040.
- Over-shift: init 10'h200, slice0=15, mode ASR -> 10'h3FF; mode LSR -> 10'h000; mode LSL -> 10'h000. With SHACC_OVERSHIFT_FLAG_EN, out_overshift=1; with all slices <10, out_overshift=0.
- Backpressure and input isolation: hold out_ready=0 for 20 cycles in DONE -> out_data stable, in_ready=0. Toggling in_init/in_amts/in_mode during RUN/DONE has no effect. Raising out_ready -> IDLE next cycle.
- Back-to-back: in_valid held high with two queued requests, LSL init 10'h001 all slices 0, then slice0=9 -> results 10'h001 then 10'h200. No request lost or duplicated.
